// File: rtl/uart_pkg.sv
// Shared types and constants for the UART command parser.
// Parser states, frame byte codes and error cause codes.
package uart_pkg;

  typedef enum logic [2:0] {
    HUNT,
    CMD,
    ADDR,
    DLO,
    DHI,
    CHK
  } parser_state_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_CHKSUM  = 2'd1,
    ERR_BADCMD  = 2'd2,
    ERR_TIMEOUT = 2'd3
  } err_cause_t;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam logic [7:0] CMD_WRITE = 8'h01;
  localparam logic [7:0] CMD_READ  = 8'h02;

endpackage

// File: rtl/uart_idle_timer.sv
// Idle timer: counts cycles while enabled, restarts on clear.
// Ports: clk, rst, clear, enable in; expired out (one-cycle pulse).
module uart_idle_timer #(
  parameter int TIMEOUT_CYCLES = 12_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [W-1:0] TERM = W'(TIMEOUT_CYCLES - 1);
  localparam logic [W-1:0] MAX  = {W{1'b1}};

  logic [W-1:0] cnt;

  // Saturating past TERM keeps expired a single pulse
  // even if enable stays high afterwards.
  always_ff @(posedge clk) begin
    if (rst || clear || !enable) begin
      cnt <= '0;
    end else if (cnt != MAX) begin
      cnt <= cnt + 1'b1;
    end
  end

  // A clear on the terminal cycle suppresses the pulse.
  assign expired = enable && !clear && (cnt == TERM);

endmodule

// File: rtl/uart_cmd_parser.sv
// Assembles A5-framed UART commands into bus write/read strobes.
// Ports: clk, rst, rx_data/rx_valid in; wr_en, rd_en, addr, wdata, err, err_cause out.
module uart_cmd_parser
  import uart_pkg::*;
#(
  parameter int CLK_FREQ       = 12_000_000,
  parameter int TIMEOUT_CYCLES = 12_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        wr_en,
  output logic        rd_en,
  output logic [7:0]  addr,
  output logic [15:0] wdata,
  output logic        err,
  output logic [1:0]  err_cause
);

  parser_state_t state;
  logic [7:0] xsum;
  logic [7:0] cmd_q;
  logic [7:0] addr_q;
  logic [7:0] dlo_q;
  logic [7:0] dhi_q;
  logic       expired;

  uart_idle_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (rx_valid),
    .enable (state != HUNT),
    .expired(expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= HUNT;
      xsum      <= '0;
      cmd_q     <= '0;
      addr_q    <= '0;
      dlo_q     <= '0;
      dhi_q     <= '0;
      wr_en     <= 1'b0;
      rd_en     <= 1'b0;
      err       <= 1'b0;
      addr      <= '0;
      wdata     <= '0;
      err_cause <= ERR_NONE;
    end else begin
      wr_en <= 1'b0;
      rd_en <= 1'b0;
      err   <= 1'b0;
      // expired already excludes a coincident byte
      if (expired) begin
        state     <= HUNT;
        err       <= 1'b1;
        err_cause <= ERR_TIMEOUT;
      end else if (rx_valid) begin
        unique case (state)
          HUNT: begin
            if (rx_data == SYNC_BYTE) begin
              state <= CMD;
              xsum  <= '0;
            end
          end
          CMD: begin
            cmd_q <= rx_data;
            xsum  <= xsum ^ rx_data;
            state <= ADDR;
          end
          ADDR: begin
            addr_q <= rx_data;
            xsum   <= xsum ^ rx_data;
            state  <= DLO;
          end
          DLO: begin
            dlo_q <= rx_data;
            xsum  <= xsum ^ rx_data;
            state <= DHI;
          end
          DHI: begin
            dhi_q <= rx_data;
            xsum  <= xsum ^ rx_data;
            state <= CHK;
          end
          CHK: begin
            state <= HUNT;
            if (rx_data != xsum) begin
              err       <= 1'b1;
              err_cause <= ERR_CHKSUM;
            end else if (cmd_q == CMD_WRITE) begin
              wr_en <= 1'b1;
              addr  <= addr_q;
              wdata <= {dhi_q, dlo_q};
            end else if (cmd_q == CMD_READ) begin
              rd_en <= 1'b1;
              addr  <= addr_q;
            end else begin
              err       <= 1'b1;
              err_cause <= ERR_BADCMD;
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Randomized self-checking bench for uart_cmd_parser.
// Compares every cycle against a queue-based frame model.
module tb_uart_cmd_parser;

  localparam int T = 50;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        wr_en;
  logic        rd_en;
  logic [7:0]  addr;
  logic [15:0] wdata;
  logic        err;
  logic [1:0]  err_cause;

  uart_cmd_parser #(
    .CLK_FREQ      (12_000_000),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .wr_en    (wr_en),
    .rd_en    (rd_en),
    .addr     (addr),
    .wdata    (wdata),
    .err      (err),
    .err_cause(err_cause)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  string ph = "reset";

  logic [7:0]  frame[$];
  int          cycn = 0;
  int          last = 0;
  logic        e_wr = 0;
  logic        e_rd = 0;
  logic        e_err = 0;
  logic [7:0]  e_addr = 0;
  logic [15:0] e_wdata = 0;
  logic [1:0]  e_cause = 0;
  int          n_wr = 0;
  int          n_rd = 0;
  int          n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s.%s got=%0h exp=%0h", ph, tag, got, exp);
    end
  endtask

  // Frame-level model: a frame is a queue starting with A5;
  // it ends on its 6th byte, on reset, or after T byte-less edges.
  task automatic model(input logic v, input logic [7:0] d,
                       input logic r);
    logic [7:0] x;
    cycn++;
    e_wr = 0;
    e_rd = 0;
    e_err = 0;
    if (r) begin
      frame.delete();
      e_addr = 0;
      e_wdata = 0;
      e_cause = 0;
    end else if (v) begin
      last = cycn;
      if (frame.size() == 0) begin
        if (d == 8'hA5) frame.push_back(d);
      end else begin
        frame.push_back(d);
        if (frame.size() == 6) begin
          x = frame[1] ^ frame[2] ^ frame[3] ^ frame[4];
          if (x != frame[5]) begin
            e_err = 1;
            e_cause = 1;
          end else if (frame[1] == 8'h01) begin
            e_wr = 1;
            e_addr = frame[2];
            e_wdata = {frame[4], frame[3]};
          end else if (frame[1] == 8'h02) begin
            e_rd = 1;
            e_addr = frame[2];
          end else begin
            e_err = 1;
            e_cause = 2;
          end
          frame.delete();
        end
      end
    end else if (frame.size() != 0 && cycn - last == T) begin
      e_err = 1;
      e_cause = 3;
      frame.delete();
    end
  endtask

  task automatic cyc(input logic v, input logic [7:0] d, input logic r);
    @(negedge clk);
    rx_valid = v;
    rx_data  = v ? d : 8'($urandom);
    rst      = r;
    @(posedge clk);
    #1;
    model(v, d, r);
    chk("wr_en", 32'(wr_en), 32'(e_wr));
    chk("rd_en", 32'(rd_en), 32'(e_rd));
    chk("err", 32'(err), 32'(e_err));
    chk("addr", 32'(addr), 32'(e_addr));
    chk("wdata", 32'(wdata), 32'(e_wdata));
    chk("cause", 32'(err_cause), 32'(e_cause));
    chk("mutex", 32'((32'(wr_en) + 32'(rd_en) + 32'(err)) <= 1), 32'd1);
    n_wr += int'(wr_en);
    n_rd += int'(rd_en);
    n_err += int'(err);
  endtask

  task automatic b(input logic [7:0] d);
    cyc(1'b1, d, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 1'b0);
  endtask

  task automatic frm(input logic [7:0] c, input logic [7:0] a,
                     input logic [7:0] lo, input logic [7:0] hi,
                     input logic [7:0] ck);
    b(8'hA5); b(c); b(a); b(lo); b(hi); b(ck);
  endtask

  task automatic snap(output int w, output int r, output int e);
    w = n_wr;
    r = n_rd;
    e = n_err;
  endtask

  initial begin
    int w0, r0, e0, k;
    logic [7:0] c, a, lo, hi, ck;

    cyc(1'b0, 8'h00, 1'b1);
    cyc(1'b0, 8'h00, 1'b1);
    chk("rst_addr", 32'(addr), 32'h0);
    chk("rst_wdata", 32'(wdata), 32'h0);
    idle(2);

    ph = "write";
    snap(w0, r0, e0);
    frm(8'h01, 8'h10, 8'h34, 8'h12, 8'h37);
    idle(1);
    chk("n_wr", 32'(n_wr - w0), 32'd1);
    chk("addr_hold", 32'(addr), 32'h10);
    chk("wdata_hold", 32'(wdata), 32'h1234);

    ph = "read";
    snap(w0, r0, e0);
    b(8'h00); b(8'hFF); b(8'h3C);
    frm(8'h02, 8'h20, 8'h00, 8'h00, 8'h22);
    idle(1);
    chk("n_rd", 32'(n_rd - r0), 32'd1);
    chk("n_err", 32'(n_err - e0), 32'd0);

    ph = "badchk";
    snap(w0, r0, e0);
    frm(8'h01, 8'h10, 8'h34, 8'h12, 8'h36);
    frm(8'h01, 8'h44, 8'hCD, 8'hAB, 8'h01 ^ 8'h44 ^ 8'hCD ^ 8'hAB);
    idle(1);
    chk("n_err", 32'(n_err - e0), 32'd1);
    chk("n_wr", 32'(n_wr - w0), 32'd1);

    ph = "badcmd";
    frm(8'h07, 8'hA5, 8'h00, 8'h00, 8'hA2);
    idle(1);
    chk("cause2", 32'(err_cause), 32'd2);

    ph = "timeout";
    snap(w0, r0, e0);
    b(8'hA5); b(8'h01);
    idle(T + 3);
    chk("n_err", 32'(n_err - e0), 32'd1);
    chk("cause3", 32'(err_cause), 32'd3);

    ph = "termcnt";
    snap(w0, r0, e0);
    b(8'hA5); b(8'h01);
    idle(T - 1);
    b(8'h10); b(8'h34); b(8'h12); b(8'h37);
    frm(8'h02, 8'h55, 8'h00, 8'h00, 8'h57);
    idle(1);
    chk("n_err", 32'(n_err - e0), 32'd0);
    chk("n_wr", 32'(n_wr - w0), 32'd1);
    chk("n_rd", 32'(n_rd - r0), 32'd1);

    ph = "midrst";
    snap(w0, r0, e0);
    b(8'hA5); b(8'h01); b(8'h10);
    cyc(1'b0, 8'h00, 1'b1);
    b(8'h34); b(8'h12); b(8'h37);
    idle(2);
    chk("n_any", 32'((n_wr - w0) + (n_rd - r0) + (n_err - e0)), 32'd0);
    frm(8'h01, 8'h10, 8'h34, 8'h12, 8'h37);
    idle(1);
    chk("n_wr", 32'(n_wr - w0), 32'd1);

    ph = "random";
    for (int f = 0; f < 400; f++) begin
      k = int'($urandom_range(0, 99));
      c = (k < 40) ? 8'h01 : (k < 80) ? 8'h02 : 8'($urandom);
      a = 8'($urandom);
      lo = 8'($urandom);
      hi = 8'($urandom);
      ck = c ^ a ^ lo ^ hi;
      if ($urandom_range(0, 9) == 0) ck = ck ^ 8'(1 << $urandom_range(0, 7));
      if ($urandom_range(0, 4) == 0) begin
        for (int g = 0; g < int'($urandom_range(1, 4)); g++) b(8'($urandom));
      end
      for (int i = 0; i < 6; i++) begin
        k = int'($urandom_range(0, 99));
        if (k < 3) idle(T - 1 + int'($urandom_range(0, 2)));
        else if (k < 13) idle(int'($urandom_range(1, 5)));
        else if (k < 14) cyc(1'b0, 8'h00, 1'b1);
        unique case (i)
          0: b(8'hA5);
          1: b(c);
          2: b(a);
          3: b(lo);
          4: b(hi);
          default: b(ck);
        endcase
      end
    end
    idle(T + 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
